// File: rtl/data_mem_initiator.sv
// Load/store initiator between the pipeline and a fixed-latency data memory.
// Each accepted request is checked for alignment and range, then either aborted or held on the memory port.
module data_mem_initiator #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        misalign_o,
    output logic        oob_o,
    output logic        stall_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        write_r, write_s;
    logic [29:0] idx_r, idx_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] rdata_r, rdata_s;
    logic        misalign_r, misalign_s;
    logic        oob_r, oob_s;
    logic        handshake_s;
    logic        req_misalign_s;
    logic        req_oob_s;

    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

    function automatic logic word_out_of_range(input logic [29:0] idx);
        logic [31:0] idx32;
        idx32 = {2'b00, idx};
        return (idx32 >= 32'(DEPTH_WORDS));
    endfunction

    assign handshake_s    = req_valid_i & (state_r == IDLE);
    // Misalignment wins, so at most one error flag is ever raised.
    assign req_misalign_s = addr_misaligned(req_addr_i[1:0]);
    assign req_oob_s      = ~req_misalign_s & word_out_of_range(req_addr_i[31:2]);

    // State and latched-request registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            write_r    <= 1'b0;
            idx_r      <= 30'd0;
            wdata_r    <= 32'd0;
            rdata_r    <= 32'd0;
            misalign_r <= 1'b0;
            oob_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            write_r    <= write_s;
            idx_r      <= idx_s;
            wdata_r    <= wdata_s;
            rdata_r    <= rdata_s;
            misalign_r <= misalign_s;
            oob_r      <= oob_s;
        end
    end

    // Next-state logic and request capture.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        write_s    = write_r;
        idx_s      = idx_r;
        wdata_s    = wdata_r;
        rdata_s    = rdata_r;
        misalign_s = misalign_r;
        oob_s      = oob_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    write_s    = req_write_i;
                    idx_s      = req_addr_i[31:2];
                    wdata_s    = req_wdata_i;
                    rdata_s    = 32'd0;
                    misalign_s = req_misalign_s;
                    oob_s      = req_oob_s;
                    if (req_misalign_s | req_oob_s) begin
                        state_s = RESP;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = ACCESS;
                        cnt_s   = 4'(MEM_LATENCY - 1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // Memory data is combinational on the address; sample it in the last held cycle.
                if (cnt_r == 4'd0) begin
                    rdata_s = write_r ? 32'd0 : mem_rdata_i;
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s    = IDLE;
                rdata_s    = 32'd0;
                misalign_s = 1'b0;
                oob_s      = 1'b0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Output decode; every output is a function of flops except the stall look-ahead on req_valid_i.
    always_comb begin
        req_ready_o  = (state_r == IDLE);
        resp_valid_o = (state_r == RESP);
        stall_o      = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_wdata_o  = 32'd0;
        resp_rdata_o = 32'd0;
        misalign_o   = 1'b0;
        oob_o        = 1'b0;
        if (state_r == ACCESS) begin
            stall_o     = 1'b1;
            mem_read_o  = ~write_r;
            mem_write_o = write_r;
            mem_addr_o  = {2'b00, idx_r};
            mem_wdata_o = write_r ? wdata_r : 32'd0;
        end else begin
            stall_o = (state_r == IDLE) & req_valid_i & ~rst_i;
        end
        if (state_r == RESP) begin
            resp_rdata_o = rdata_r;
            misalign_o   = misalign_r;
            oob_o        = oob_r;
        end else begin
            resp_rdata_o = 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator with a memory model and a response scoreboard.
module tb_data_mem_initiator;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        req_ready_o, resp_valid_o, misalign_o, oob_o, stall_o;
    logic        mem_write_o, mem_read_o;
    logic [31:0] resp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

    data_mem_initiator #(.MEM_LATENCY(2), .DEPTH_WORDS(256)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o),
        .resp_rdata_o(resp_rdata_o), .misalign_o(misalign_o), .oob_o(oob_o),
        .stall_o(stall_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Data memory behind the port, cleared while reset is held across an edge.
    logic [31:0] mem [0:255];
    assign mem_rdata_i = mem[mem_addr_o[7:0]];
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (mem_write_o) begin
            mem[mem_addr_o[7:0]] <= mem_wdata_o;
        end
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        oob;
        int          at_cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] model_mem [0:255];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Response monitor: pops the scoreboard on every completion, otherwise expects quiet outputs.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (resp_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata_o, e.rdata);
                    chk("resp_misalign", 32'(misalign_o), 32'(e.mis));
                    chk("resp_oob", 32'(oob_o), 32'(e.oob));
                    chk("resp_cycle", 32'(cyc), 32'(e.at_cyc));
                end
            end else begin
                chk("idle_resp_fields", {resp_rdata_o[31:2], misalign_o, oob_o}, 32'd0);
            end
        end
    end

    // Starts at a negedge in IDLE, finishes at the next IDLE negedge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic keep);
        logic mis, oob, err;
        int   lat, c0;
        exp_t e;
        mis = (addr[1:0] != 2'b00);
        oob = !mis && (addr[31:2] >= 30'd256);
        err = mis | oob;
        lat = err ? 1 : 3;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        #1;
        chk("accept_ready", 32'(req_ready_o), 32'd1);
        chk("accept_stall", 32'(stall_o), 32'd1);
        c0 = cyc;
        e.rdata  = (err || wr) ? 32'd0 : model_mem[addr[9:2]];
        e.mis    = mis;
        e.oob    = oob;
        e.at_cyc = c0 + lat;
        sb.push_back(e);
        if (!err && wr) model_mem[addr[9:2]] = wd;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk_i);
            if (!keep) req_valid_i = 1'b0;
            chk("busy_not_ready", 32'(req_ready_o), 32'd0);
            if (!err && k < lat) begin
                chk("acc_write", 32'(mem_write_o), 32'(wr));
                chk("acc_read", 32'(mem_read_o), 32'(!wr));
                chk("acc_addr", mem_addr_o, {2'b00, addr[31:2]});
                chk("acc_wdata", mem_wdata_o, wr ? wd : 32'd0);
                chk("acc_stall", 32'(stall_o), 32'd1);
            end else begin
                chk("no_strobe", {mem_addr_o[31:2], mem_write_o, mem_read_o}, 32'd0);
                chk("resp_stall", 32'(stall_o), 32'd0);
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_outputs", {resp_rdata_o[31:5], resp_valid_o, misalign_o, oob_o, mem_write_o, mem_read_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o | mem_wdata_o, 32'd0);
        rst_i = 1'b0;

        // Store then load back, error cases, upper boundary
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 32'h0000_0010, 32'd0, 1'b0);
        issue(1'b0, 32'h0000_0013, 32'd0, 1'b0);
        issue(1'b0, 32'h0000_0400, 32'd0, 1'b0);
        issue(1'b0, 32'h0000_0401, 32'd0, 1'b0);
        issue(1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 1'b0);
        issue(1'b0, 32'h0000_03FC, 32'd0, 1'b0);
        chk("idle_no_valid_stall", 32'(stall_o), 32'd0);

        // req_valid_i held high across a burst of back-to-back requests
        issue(1'b1, 32'h0000_0008, 32'h0000_0011, 1'b1);
        issue(1'b0, 32'h0000_0008, 32'd0, 1'b1);
        issue(1'b0, 32'h0000_0402, 32'd0, 1'b1);
        issue(1'b0, 32'h0000_0003, 32'd0, 1'b1);
        issue(1'b1, 32'h0000_0014, 32'h7777_0001, 1'b1);
        issue(1'b0, 32'h0000_0010, 32'd0, 1'b0);

        // Reset during the first access cycle of a store
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 32'h0000_0020;
        req_wdata_i = 32'h1234_5678;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_write", 32'(mem_write_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("rst_drop_write", 32'(mem_write_o), 32'd0);
        chk("rst_ready_mid", 32'(req_ready_o), 32'd1);
        chk("rst_quiet_mid", {mem_addr_o[31:3], resp_valid_o, stall_o, mem_read_o}, 32'd0);
        #1 rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        issue(1'b0, 32'h0000_0020, 32'd0, 1'b0);

        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_initiator.md
DATA_MEM_INITIATOR -- requirements
Module: data_mem_initiator

Interface
REQ-001 Parameter MEM_LATENCY, default 2, cycles the memory port is held per access (legal range 1..15).
REQ-002 Parameter DEPTH_WORDS, default 256, number of addressable 32-bit words behind the port.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  input  1  pipeline requests a memory access.
REQ-006 req_write_i  input  1  1 = store, 0 = load; sampled with req_valid_i.
REQ-007 req_addr_i  input  32  byte address.
REQ-008 req_wdata_i  input  32  store data.
REQ-009 req_ready_o  output  1  block can accept a request this cycle.
REQ-010 resp_valid_o  output  1  one-cycle pulse: access complete.
REQ-011 resp_rdata_o  output  32  load data, valid while resp_valid_o=1.
REQ-012 misalign_o  output  1  with resp_valid_o: request aborted, addr[1:0]!=0.
REQ-013 oob_o  output  1  with resp_valid_o: request aborted, word index >= DEPTH_WORDS.
REQ-014 stall_o  output  1  pipeline must hold: access in flight.
REQ-015 mem_addr_o  output  32  word index to data memory.
REQ-016 mem_wdata_o  output  32  write data to data memory.
REQ-017 mem_write_o  output  1  memory write strobe.
REQ-018 mem_read_o  output  1  memory read strobe.
REQ-019 mem_rdata_i  input  32  read data from data memory (combinational on mem_addr_o).

Function
REQ-020 FSM states IDLE, ACCESS, RESP; encoding free.
REQ-021 req_ready_o SHALL be 1 exactly when state=IDLE; handshake = req_valid_i & req_ready_o.
REQ-022 On handshake, block SHALL latch write flag, addr, wdata; requests while not ready SHALL be ignored.
REQ-023 Word index = req_addr_i[31:2]; misaligned if req_addr_i[1:0]!=0; out-of-bounds if word index >= DEPTH_WORDS; misalign checked first.
REQ-024 Handshake with error: IDLE->RESP directly, no memory strobe ever asserted, resp_rdata_o=0, exactly one of misalign_o/oob_o =1.
REQ-025 Handshake without error: IDLE->ACCESS, latency counter loaded with MEM_LATENCY-1.
REQ-026 In ACCESS: mem_addr_o=latched word index, mem_read_o=~write, mem_write_o=write, mem_wdata_o=latched wdata for stores else 0; all stable for the whole state.
REQ-027 Counter decrements each ACCESS cycle; at count 0 block SHALL capture mem_rdata_i (loads) and go to RESP.
REQ-028 Outside ACCESS: mem_read_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-029 RESP lasts exactly one cycle: resp_valid_o=1, then IDLE; stores return resp_rdata_o=0.
REQ-030 Latency: handshake edge at cycle 0 -> resp_valid_o high in cycle MEM_LATENCY+1 (success) or cycle 1 (error).
REQ-031 stall_o SHALL be 1 in ACCESS, and in IDLE when req_valid_i=1 (combinational), else 0.
REQ-032 Back-to-back: new request accepted in the IDLE cycle after RESP; no request accepted in RESP.
REQ-033 resp_rdata_o, misalign_o, oob_o SHALL be 0 whenever resp_valid_o=0.

Reset
REQ-034 rst_i=1 SHALL immediately force state IDLE, counter 0, all latched registers 0, all outputs 0 except req_ready_o=1.
REQ-035 Reset mid-ACCESS SHALL drop memory strobes asynchronously, abandon the access, and produce no resp_valid_o.
REQ-036 After rst_i falls, first handshake possible on the next rising edge.

Verification
REQ-037 MEM_LATENCY=2; store addr 0x10, data 0xDEADBEEF -> mem_write_o=1, mem_addr_o=4 for cycles 1-2, resp_valid_o in cycle 3, rdata 0.
REQ-038 Load addr 0x10 after REQ-037 (memory model) -> mem_read_o cycles 1-2, resp_valid_o cycle 3, resp_rdata_o=0xDEADBEEF.
REQ-039 Load addr 0x13 -> no strobes, resp_valid_o cycle 1, misalign_o=1, oob_o=0.
REQ-040 Load addr 0x400 (index 256) -> no strobes, resp_valid_o cycle 1, oob_o=1.
REQ-041 req_valid_i held high continuously with new addrs -> accepts only in IDLE, one response per accept, stall_o high between.
REQ-042 rst_i pulsed in cycle 1 of a store -> mem_write_o falls same cycle, no resp_valid_o, req_ready_o=1.
